// File: rtl/core_defs.sv
// Shared core definitions: datapath widths and EX-stage op encodings.
// Used by the ID/EX latch, shifter4 and the ALU.
package core_defs;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    SH_ROL = 2'b00,
    SH_SLL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRL = 2'b11
  } shift_op_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/dff_en_ar.sv
// Enabled register bank with asynchronous active-high clear.
// Shared building block for pipeline latches.
module dff_en_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: stall hold, flush bubbles, halt drain,
// and a saturating bubble counter.
module id_ex_latch
  import core_defs::*;
#(
  parameter int DW = core_defs::DW,
  parameter int RW = core_defs::RW,
  parameter int CW = core_defs::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc2,
  input  logic [1:0]    id_shift_op,
  input  logic [2:0]    id_alu_op,
  input  logic          id_use_imm,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_wr,
  input  logic          id_mem_rd,
  input  logic          id_mem_wr,
  input  logic          id_halt,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_pc2,
  output logic [1:0]    ex_shift_op,
  output logic [2:0]    ex_alu_op,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_wr,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic          ex_halt,
  output logic [CW-1:0] bubble_cnt
);

  localparam int PW = 3*DW + 2 + 3 + RW + 3;

  logic          en;
  logic [DW-1:0] b_sel;
  logic [PW-1:0] pd;
  logic [PW-1:0] pq;
  logic          reg_wr_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic          halted;
  logic          v_d;
  logic          h_d;
  logic          bump;
  logic          cnt_en;
  logic [CW-1:0] cnt_d;

  assign en    = !stall | flush;
  assign b_sel = id_use_imm ? id_imm : id_rt_data;

  assign pd = {id_rs_data, b_sel, id_pc2,
               id_shift_op, id_alu_op, id_rd,
               id_reg_wr, id_mem_rd, id_mem_wr};

  dff_en_ar #(.W(PW)) u_data (
    .clk(clk), .rst(rst), .en(en),
    .d(pd), .q(pq)
  );

  assign {ex_a, ex_b, ex_pc2,
          ex_shift_op, ex_alu_op, ex_rd,
          reg_wr_q, mem_rd_q, mem_wr_q} = pq;

  // Once halted the front end is frozen: captures only yield bubbles.
  assign v_d = !flush & id_valid & !halted;
  assign h_d = halted | (!flush & id_valid & id_halt);

  dff_en_ar #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .en(en),
    .d(v_d), .q(ex_valid)
  );

  dff_en_ar #(.W(1)) u_halt (
    .clk(clk), .rst(rst), .en(en),
    .d(h_d), .q(halted)
  );

  assign bump   = !halted & (flush | (!stall & !id_valid));
  assign cnt_en = bump & ~&bubble_cnt;
  assign cnt_d  = bubble_cnt + 1'b1;

  dff_en_ar #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .en(cnt_en),
    .d(cnt_d), .q(bubble_cnt)
  );

  assign ex_reg_wr = reg_wr_q & ex_valid;
  assign ex_mem_rd = mem_rd_q & ex_valid;
  assign ex_mem_wr = mem_wr_q & ex_valid;
  assign ex_halt   = halted;

endmodule

// File: tb/tb_id_ex_latch.sv
// Bench for id_ex_latch: directed table, corner sequences,
// and random traffic against a rule-level model.
module tb_id_ex_latch;
  import core_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_valid, stall, flush;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc2;
  logic [1:0]  id_shift_op;
  logic [2:0]  id_alu_op;
  logic        id_use_imm;
  logic [2:0]  id_rd;
  logic        id_reg_wr, id_mem_rd, id_mem_wr, id_halt;

  logic        ex_valid;
  logic [15:0] ex_a, ex_b, ex_pc2;
  logic [1:0]  ex_shift_op;
  logic [2:0]  ex_alu_op;
  logic [2:0]  ex_rd;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt;
  logic [15:0] bubble_cnt;

  logic        s_valid;
  logic [15:0] s_a, s_b, s_pc2;
  logic [1:0]  s_sh;
  logic [2:0]  s_alu;
  logic [2:0]  s_rd;
  logic        s_rw, s_mr, s_mw, s_halt;
  logic [3:0]  s_cnt;

  id_ex_latch dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc2(id_pc2),
    .id_shift_op(id_shift_op), .id_alu_op(id_alu_op),
    .id_use_imm(id_use_imm), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_halt(id_halt),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_pc2(ex_pc2), .ex_shift_op(ex_shift_op),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow counter copy so saturation is reachable quickly.
  id_ex_latch #(.CW(4)) dut_s (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc2(id_pc2),
    .id_shift_op(id_shift_op), .id_alu_op(id_alu_op),
    .id_use_imm(id_use_imm), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_halt(id_halt),
    .ex_valid(s_valid), .ex_a(s_a), .ex_b(s_b),
    .ex_pc2(s_pc2), .ex_shift_op(s_sh),
    .ex_alu_op(s_alu), .ex_rd(s_rd),
    .ex_reg_wr(s_rw), .ex_mem_rd(s_mr),
    .ex_mem_wr(s_mw), .ex_halt(s_halt),
    .bubble_cnt(s_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_valid, m_halted;
  int          m_cnt;
  logic [15:0] m_a, m_b, m_pc2;
  logic [1:0]  m_sh;
  logic [2:0]  m_alu, m_rd;
  bit          m_rw, m_mr, m_mw;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_halted = 0; m_cnt = 0;
    m_a = 0; m_b = 0; m_pc2 = 0;
    m_sh = 0; m_alu = 0; m_rd = 0;
    m_rw = 0; m_mr = 0; m_mw = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      if (!m_halted) m_cnt++;
      m_valid = 0;
    end else if (!stall) begin
      if (!m_halted && !id_valid) m_cnt++;
      m_valid = id_valid && !m_halted;
      m_a   = id_rs_data;
      m_b   = id_use_imm ? id_imm : id_rt_data;
      m_pc2 = id_pc2;
      m_sh  = id_shift_op;
      m_alu = id_alu_op;
      m_rd  = id_rd;
      m_rw  = id_reg_wr;
      m_mr  = id_mem_rd;
      m_mw  = id_mem_wr;
      if (id_valid && id_halt) m_halted = 1;
    end
  endtask

  task automatic check_all(string t);
    int e16, e4;
    e16 = (m_cnt > 65535) ? 65535 : m_cnt;
    e4  = (m_cnt > 15) ? 15 : m_cnt;
    chk({t, ".valid"}, ex_valid, m_valid);
    chk({t, ".halt"}, ex_halt, m_halted);
    chk({t, ".reg_wr"}, ex_reg_wr, m_valid & m_rw);
    chk({t, ".mem_rd"}, ex_mem_rd, m_valid & m_mr);
    chk({t, ".mem_wr"}, ex_mem_wr, m_valid & m_mw);
    chk({t, ".cnt"}, bubble_cnt, e16);
    chk({t, ".cnt4"}, s_cnt, e4);
    if (m_valid) begin
      chk({t, ".a"}, ex_a, m_a);
      chk({t, ".b"}, ex_b, m_b);
      chk({t, ".pc2"}, ex_pc2, m_pc2);
      chk({t, ".sh"}, ex_shift_op, m_sh);
      chk({t, ".alu"}, ex_alu_op, m_alu);
      chk({t, ".rd"}, ex_rd, m_rd);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; stall = 0; flush = 0;
    id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_pc2 = 0;
    id_shift_op = 0; id_alu_op = 0;
    id_use_imm = 0; id_rd = 0;
    id_reg_wr = 0; id_mem_rd = 0;
    id_mem_wr = 0; id_halt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    logic v, st, fl;
    logic [15:0] rs, rt, imm;
    logic ui;
    logic [1:0] sh;
    logic rw, hl;
    logic ev;
    logic [15:0] ea, eb;
    logic erw, eh;
    int ec;
    logic cd;
  } vec_t;

  function automatic vec_t mk(
    logic v, logic st, logic fl,
    logic [15:0] rs, logic [15:0] rt,
    logic [15:0] imm, logic ui,
    logic [1:0] sh, logic rw, logic hl,
    logic ev, logic [15:0] ea,
    logic [15:0] eb, logic erw,
    logic eh, int ec, logic cd);
    vec_t r;
    r.v = v; r.st = st; r.fl = fl;
    r.rs = rs; r.rt = rt; r.imm = imm;
    r.ui = ui; r.sh = sh; r.rw = rw;
    r.hl = hl; r.ev = ev; r.ea = ea;
    r.eb = eb; r.erw = erw; r.eh = eh;
    r.ec = ec; r.cd = cd;
    return r;
  endfunction

  vec_t tbl[13];

  initial begin
    logic [15:0] sll;

    tbl[0]  = mk(1,0,0,16'h8001,16'h1111,16'h2222,0,2'b01,1,0,
                 1,16'h8001,16'h1111,1,0,0,1);
    tbl[1]  = mk(1,1,0,16'h0001,16'h1111,16'h2222,0,2'b01,1,0,
                 1,16'h8001,16'h1111,1,0,0,1);
    tbl[2]  = mk(0,1,0,16'h0002,16'h1111,16'h2222,0,2'b01,1,0,
                 1,16'h8001,16'h1111,1,0,0,1);
    tbl[3]  = mk(1,1,0,16'h0003,16'h1111,16'h2222,0,2'b01,1,0,
                 1,16'h8001,16'h1111,1,0,0,1);
    tbl[4]  = mk(1,1,1,16'h0004,16'h1111,16'h2222,0,2'b01,1,0,
                 0,16'h0000,16'h0000,0,0,1,0);
    tbl[5]  = mk(0,0,0,16'h0000,16'h0000,16'h0000,0,2'b00,1,0,
                 0,16'h0000,16'h0000,0,0,2,0);
    tbl[6]  = mk(1,0,0,16'h5555,16'h1234,16'hABCD,1,2'b10,0,0,
                 1,16'h5555,16'hABCD,0,0,2,1);
    tbl[7]  = mk(1,0,0,16'h0007,16'h0070,16'h0700,0,2'b11,1,1,
                 1,16'h0007,16'h0070,1,1,2,1);
    tbl[8]  = mk(1,0,0,16'h0009,16'h0000,16'h0000,0,2'b00,1,0,
                 0,16'h0000,16'h0000,0,1,2,0);
    tbl[9]  = mk(1,0,0,16'h000A,16'h0000,16'h0000,0,2'b00,1,0,
                 0,16'h0000,16'h0000,0,1,2,0);
    tbl[10] = mk(1,0,0,16'h000B,16'h0000,16'h0000,0,2'b00,1,0,
                 0,16'h0000,16'h0000,0,1,2,0);
    tbl[11] = mk(1,0,0,16'h000C,16'h0000,16'h0000,0,2'b00,1,0,
                 0,16'h0000,16'h0000,0,1,2,0);
    tbl[12] = mk(0,0,1,16'h000D,16'h0000,16'h0000,0,2'b00,0,0,
                 0,16'h0000,16'h0000,0,1,2,0);

    clear_inputs();
    rst = 1;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", ex_valid, 0);
    chk("reset.cnt", bubble_cnt, 0);
    chk("reset.halt", ex_halt, 0);
    rst = 0;

    // Directed table from reset
    foreach (tbl[i]) begin
      id_valid = tbl[i].v; stall = tbl[i].st;
      flush = tbl[i].fl;
      id_rs_data = tbl[i].rs; id_rt_data = tbl[i].rt;
      id_imm = tbl[i].imm; id_use_imm = tbl[i].ui;
      id_shift_op = tbl[i].sh; id_reg_wr = tbl[i].rw;
      id_halt = tbl[i].hl;
      step();
      chk($sformatf("tbl%0d.valid", i), ex_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.reg_wr", i), ex_reg_wr, tbl[i].erw);
      chk($sformatf("tbl%0d.halt", i), ex_halt, tbl[i].eh);
      chk($sformatf("tbl%0d.cnt", i), bubble_cnt, tbl[i].ec);
      if (tbl[i].cd) begin
        chk($sformatf("tbl%0d.a", i), ex_a, tbl[i].ea);
        chk($sformatf("tbl%0d.b", i), ex_b, tbl[i].eb);
      end
      if (i == 0) begin
        chk("tbl0.sh", ex_shift_op, SH_SLL);
        sll = {ex_a[14:0], 1'b0};
        chk("tbl0.sll1", sll, 16'h0002);
      end
    end

    // Flush on the halt-capture edge cancels the halt
    clear_inputs();
    do_reset();
    id_valid = 1; id_halt = 1; flush = 1;
    step();
    chk("hflush.valid", ex_valid, 0);
    chk("hflush.halt", ex_halt, 0);
    chk("hflush.cnt", bubble_cnt, 1);
    clear_inputs();
    id_valid = 1; id_rs_data = 16'hBEEF; id_reg_wr = 1;
    step();
    chk("hflush.next_valid", ex_valid, 1);
    chk("hflush.next_halt", ex_halt, 0);
    chk("hflush.next_a", ex_a, 16'hBEEF);

    // Asynchronous reset between edges
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("arst.valid", ex_valid, 0);
    chk("arst.a", ex_a, 0);
    chk("arst.reg_wr", ex_reg_wr, 0);
    chk("arst.any", |{ex_b, ex_pc2, ex_shift_op, ex_alu_op,
                      ex_rd, ex_mem_rd, ex_mem_wr, ex_halt,
                      bubble_cnt}, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // Counter saturation on the narrow copy
    clear_inputs();
    repeat (14) step();
    chk("sat.cnt4_14", s_cnt, 4'hE);
    chk("sat.cnt_14", bubble_cnt, 14);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("sat%0d.cnt4", k), s_cnt, 4'hF);
      chk($sformatf("sat%0d.cnt", k), bubble_cnt, 15 + k);
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        rst = 1;
        #1;
        model_reset();
        check_all("rnd_rst");
        rst = 0;
      end
      id_valid    = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 6) == 0);
      id_halt     = ($urandom_range(0, 59) == 0);
      id_rs_data  = 16'($urandom);
      id_rt_data  = 16'($urandom);
      id_imm      = 16'($urandom);
      id_pc2      = 16'($urandom);
      id_shift_op = 2'($urandom);
      id_alu_op   = 3'($urandom);
      id_use_imm  = 1'($urandom);
      id_rd       = 3'($urandom);
      id_reg_wr   = 1'($urandom);
      id_mem_rd   = 1'($urandom);
      id_mem_wr   = 1'($urandom);
      step();
      check_all($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
